// File: rtl/pcie_rx_if.sv
// pcie_rx_if: bundle between the PCIe RX stream and the TLP parser outputs.
// master: stream source / consumers; slave: the pcie_rx parser.
interface pcie_rx_if #(
  parameter int ADDR_WIDTH = 13
);
  logic [63:0]           rx_tdata;
  logic                  rx_tvalid;
  logic                  rx_tlast;
  logic                  write_valid;
  logic [ADDR_WIDTH-1:0] write_address;
  logic [63:0]           write_data;
  logic                  read_valid;
  logic                  read_ready;
  logic [ADDR_WIDTH-1:0] read_address;
  logic [23:0]           read_rid_tag;
  logic                  cpl_valid;
  logic [7:0]            cpl_tag;
  logic [63:0]           cpl_data;
  logic                  cpl_last;
  logic [15:0]           unsupported_count;

  modport master (
    output rx_tdata, rx_tvalid, rx_tlast,
    output read_ready,
    input  write_valid, write_address, write_data,
    input  read_valid, read_address, read_rid_tag,
    input  cpl_valid, cpl_tag, cpl_data, cpl_last,
    input  unsupported_count
  );

  modport slave (
    input  rx_tdata, rx_tvalid, rx_tlast,
    input  read_ready,
    output write_valid, write_address, write_data,
    output read_valid, read_address, read_rid_tag,
    output cpl_valid, cpl_tag, cpl_data, cpl_last,
    output unsupported_count
  );
endinterface

// File: rtl/pcie_rx.sv
// pcie_rx: parses MWr32 / MRd32 / CplD TLPs from the 64-bit RX stream.
// Ports: clock, reset (sync, active-high), bus (pcie_rx_if.slave).
module pcie_rx #(
  parameter int ADDR_WIDTH = 13
) (
  input logic      clock,
  input logic      reset,
  pcie_rx_if.slave bus
);
  typedef enum logic [1:0] {
    HDR0, HDR1, DATA, DISCARD
  } state_t;

  typedef enum logic [1:0] {
    K_NONE, K_WR, K_RD, K_CPL
  } kind_t;

  state_t state, state_n;
  kind_t  kind, hdr_kind;

  logic [6:0]  fmt;
  logic [9:0]  len;
  logic        is_wr, is_rd, is_cpl;
  logic        beat0, beat1, data_beat;
  logic        rd_new, rd_take, rd_drop;
  logic        cnt_inc;
  logic [23:0] rid_q;
  logic [31:0] prev_hi;
  logic [63:0] word;

  logic [ADDR_WIDTH-1:0] word_addr;

  logic                  wr_v;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [63:0]           wr_data;
  logic                  rd_v;
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic [23:0]           rd_rid;
  logic                  cpl_v;
  logic [7:0]            cpl_tag_q;
  logic [63:0]           cpl_data_q;
  logic                  cpl_last_q;
  logic [15:0]           cnt;

  function automatic logic [31:0] swap(
    input logic [31:0] d
  );
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  always_comb begin
    fmt    = bus.rx_tdata[30:24];
    len    = bus.rx_tdata[9:0];
    // Even and nonzero implies at least 2 DWs.
    is_wr  = (fmt == 7'b1000000) && !len[0]
             && (len != 10'd0);
    is_rd  = (fmt == 7'b0000000) && (len == 10'd2);
    is_cpl = (fmt == 7'b1001010)
             && (bus.rx_tdata[47:45] == 3'b000);
    hdr_kind = K_NONE;
    unique case (1'b1)
      is_wr:   hdr_kind = K_WR;
      is_rd:   hdr_kind = K_RD;
      is_cpl:  hdr_kind = K_CPL;
      default: hdr_kind = K_NONE;
    endcase
  end

  always_comb begin
    beat0     = bus.rx_tvalid && (state == HDR0);
    beat1     = bus.rx_tvalid && (state == HDR1);
    data_beat = bus.rx_tvalid && (state == DATA);
    rd_new    = beat1 && (kind == K_RD);
    // A pending read being accepted this cycle frees the slot.
    rd_take   = rd_new && (!rd_v || bus.read_ready);
    rd_drop   = rd_new && rd_v && !bus.read_ready;
    cnt_inc   = (beat0 && (hdr_kind == K_NONE)) || rd_drop;
    word      = {swap(bus.rx_tdata[31:0]), swap(prev_hi)};
  end

  always_comb begin
    state_n = state;
    if (bus.rx_tvalid) begin
      if (bus.rx_tlast) begin
        state_n = HDR0;
      end else begin
        unique case (state)
          HDR0: state_n = (hdr_kind == K_NONE) ? DISCARD : HDR1;
          HDR1: state_n = (kind == K_WR || kind == K_CPL)
                          ? DATA : DISCARD;
          DATA:    state_n = DATA;
          DISCARD: state_n = DISCARD;
          default: state_n = HDR0;
        endcase
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= HDR0;
    end else begin
      state <= state_n;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      kind       <= K_NONE;
      rid_q      <= '0;
      prev_hi    <= '0;
      word_addr  <= '0;
      wr_v       <= 1'b0;
      wr_addr    <= '0;
      wr_data    <= '0;
      rd_v       <= 1'b0;
      rd_addr    <= '0;
      rd_rid     <= '0;
      cpl_v      <= 1'b0;
      cpl_tag_q  <= '0;
      cpl_data_q <= '0;
      cpl_last_q <= 1'b0;
      cnt        <= '0;
    end else begin
      wr_v       <= 1'b0;
      cpl_v      <= 1'b0;
      cpl_last_q <= 1'b0;
      if (bus.rx_tvalid) begin
        prev_hi <= bus.rx_tdata[63:32];
      end
      if (beat0) begin
        kind  <= hdr_kind;
        rid_q <= bus.rx_tdata[63:40];
      end
      if (beat1) begin
        word_addr <= bus.rx_tdata[ADDR_WIDTH+2:3];
        if (kind == K_CPL) begin
          cpl_tag_q <= bus.rx_tdata[15:8];
        end
      end
      if (rd_v && bus.read_ready) begin
        rd_v <= 1'b0;
      end
      if (rd_take) begin
        rd_v    <= 1'b1;
        rd_addr <= bus.rx_tdata[ADDR_WIDTH+2:3];
        rd_rid  <= rid_q;
      end
      if (data_beat) begin
        word_addr <= word_addr + ADDR_WIDTH'(1);
        if (kind == K_WR) begin
          wr_v    <= 1'b1;
          wr_addr <= word_addr;
          wr_data <= word;
        end else begin
          cpl_v      <= 1'b1;
          cpl_data_q <= word;
          cpl_last_q <= bus.rx_tlast;
        end
      end
      if (cnt_inc && (cnt != 16'hFFFF)) begin
        cnt <= cnt + 16'd1;
      end
    end
  end

  assign bus.write_valid       = wr_v;
  assign bus.write_address     = wr_addr;
  assign bus.write_data        = wr_data;
  assign bus.read_valid        = rd_v;
  assign bus.read_address      = rd_addr;
  assign bus.read_rid_tag      = rd_rid;
  assign bus.cpl_valid         = cpl_v;
  assign bus.cpl_tag           = cpl_tag_q;
  assign bus.cpl_data          = cpl_data_q;
  assign bus.cpl_last          = cpl_last_q;
  assign bus.unsupported_count = cnt;
endmodule

// File: tb/tb_pcie_rx.sv
// tb_pcie_rx: directed-vector bench for pcie_rx.
// Drives TLP beats on the negedge; records strobes on the negedge.
module tb_pcie_rx;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_vec = 0;
  int   n_err = 0;

  logic [12:0] wa[$];
  logic [63:0] wd[$];
  logic [7:0]  ct[$];
  logic [63:0] cd[$];
  logic        cl[$];

  always #5 clk = ~clk;

  pcie_rx_if #(.ADDR_WIDTH(13)) bus ();

  pcie_rx #(.ADDR_WIDTH(13)) dut (
    .clock (clk),
    .reset (rst),
    .bus   (bus)
  );

  always @(negedge clk) begin
    if (bus.write_valid) begin
      wa.push_back(bus.write_address);
      wd.push_back(bus.write_data);
    end
    if (bus.cpl_valid) begin
      ct.push_back(bus.cpl_tag);
      cd.push_back(bus.cpl_data);
      cl.push_back(bus.cpl_last);
    end
  end

  function automatic logic [63:0] hdr(
    input logic [6:0]  ft,
    input logic [9:0]  ln,
    input logic [31:0] dw1
  );
    return {dw1, 1'b0, ft, 14'd0, ln};
  endfunction

  task automatic beat(input logic [63:0] d, input logic last);
    @(negedge clk);
    bus.rx_tvalid = 1'b1;
    bus.rx_tdata  = d;
    bus.rx_tlast  = last;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.rx_tvalid = 1'b0;
      bus.rx_tlast  = 1'b0;
      bus.rx_tdata  = '0;
    end
  endtask

  task automatic clear_q();
    wa.delete(); wd.delete();
    ct.delete(); cd.delete(); cl.delete();
  endtask

  task automatic test_reset();
    bus.rx_tvalid  = 1'b0;
    bus.rx_tlast   = 1'b0;
    bus.rx_tdata   = '0;
    bus.read_ready = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_vec++;
    if ({bus.write_valid, bus.read_valid, bus.cpl_valid,
         bus.cpl_last} !== 4'b0000) begin
      n_err++;
      $display("FAIL reset_strobes got %b%b%b%b want 0000",
               bus.write_valid, bus.read_valid,
               bus.cpl_valid, bus.cpl_last);
    end
    n_vec++;
    if ({bus.write_address, bus.read_address} !== 26'd0) begin
      n_err++;
      $display("FAIL reset_addr got %h %h want 0 0",
               bus.write_address, bus.read_address);
    end
    n_vec++;
    if ({bus.write_data, bus.cpl_data, bus.read_rid_tag,
         bus.cpl_tag, bus.unsupported_count} !== 176'd0) begin
      n_err++;
      $display("FAIL reset_data got %h %h %h %h %h want 0",
               bus.write_data, bus.cpl_data, bus.read_rid_tag,
               bus.cpl_tag, bus.unsupported_count);
    end
    rst = 1'b0;
    idle(1);
  endtask

  task automatic test_write();
    clear_q();
    beat(hdr(7'h40, 10'd2, 32'h0), 1'b0);
    beat({32'h04030201, 32'h00000010}, 1'b0);
    beat({32'h0, 32'h08070605}, 1'b1);
    idle(2);
    n_vec++;
    if (wa.size() !== 1) begin
      n_err++;
      $display("FAIL wr_count got %0d want 1", wa.size());
    end else begin
      n_vec++;
      if (wa[0] !== 13'd2) begin
        n_err++;
        $display("FAIL wr_addr got %h want 2", wa[0]);
      end
      n_vec++;
      if (wd[0] !== 64'h05060708_01020304) begin
        n_err++;
        $display("FAIL wr_data got %h want 0506070801020304",
                 wd[0]);
      end
    end
  endtask

  task automatic test_read();
    beat(hdr(7'h00, 10'd2, 32'h01000700), 1'b0);
    beat({32'h0, 32'h00000018}, 1'b1);
    n_vec++;
    if (bus.read_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_early got %b want 0", bus.read_valid);
    end
    idle(1);
    for (int i = 0; i < 5; i++) begin
      n_vec++;
      if ({bus.read_valid, bus.read_address, bus.read_rid_tag}
          !== {1'b1, 13'd3, 24'h010007}) begin
        n_err++;
        $display("FAIL rd_hold%0d got %b %h %h want 1 3 010007",
                 i, bus.read_valid, bus.read_address,
                 bus.read_rid_tag);
      end
      idle(1);
    end
  endtask

  task automatic test_read_drop();
    beat(hdr(7'h00, 10'd2, 32'h02000900), 1'b0);
    beat({32'h0, 32'h00000040}, 1'b1);
    idle(2);
    n_vec++;
    if ({bus.read_valid, bus.read_address, bus.read_rid_tag}
        !== {1'b1, 13'd3, 24'h010007}) begin
      n_err++;
      $display("FAIL rd_drop_keep got %b %h %h want 1 3 010007",
               bus.read_valid, bus.read_address, bus.read_rid_tag);
    end
    n_vec++;
    if (bus.unsupported_count !== 16'd1) begin
      n_err++;
      $display("FAIL rd_drop_cnt got %0d want 1",
               bus.unsupported_count);
    end
  endtask

  task automatic test_read_swap();
    beat(hdr(7'h00, 10'd2, 32'h03000A00), 1'b0);
    beat({32'h0, 32'h00000050}, 1'b1);
    bus.read_ready = 1'b1;
    idle(1);
    bus.read_ready = 1'b0;
    n_vec++;
    if ({bus.read_valid, bus.read_address, bus.read_rid_tag}
        !== {1'b1, 13'd10, 24'h03000A}) begin
      n_err++;
      $display("FAIL rd_swap got %b %h %h want 1 00a 03000a",
               bus.read_valid, bus.read_address, bus.read_rid_tag);
    end
    n_vec++;
    if (bus.unsupported_count !== 16'd1) begin
      n_err++;
      $display("FAIL rd_swap_cnt got %0d want 1",
               bus.unsupported_count);
    end
    @(negedge clk);
    bus.read_ready = 1'b1;
    @(negedge clk);
    bus.read_ready = 1'b0;
    n_vec++;
    if (bus.read_valid !== 1'b0) begin
      n_err++;
      $display("FAIL rd_accept got %b want 0", bus.read_valid);
    end
  endtask

  task automatic test_gap();
    logic [12:0] ea[3];
    logic [63:0] ed[3];
    ea = '{13'd4, 13'd5, 13'd6};
    ed = '{64'h88776655_44332211,
           64'h00FFEEDD_CCBBAA99,
           64'hEFCDAB89_67452301};
    clear_q();
    beat(hdr(7'h40, 10'd6, 32'h0), 1'b0);
    beat({32'h11223344, 32'h00000020}, 1'b0);
    beat({32'h99AABBCC, 32'h55667788}, 1'b0);
    idle(2);
    beat({32'h01234567, 32'hDDEEFF00}, 1'b0);
    beat({32'h0, 32'h89ABCDEF}, 1'b1);
    idle(2);
    n_vec++;
    if (wa.size() !== 3) begin
      n_err++;
      $display("FAIL gap_count got %0d want 3", wa.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_vec++;
        if ({wa[i], wd[i]} !== {ea[i], ed[i]}) begin
          n_err++;
          $display("FAIL gap_w%0d got %h %h want %h %h",
                   i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_cpl();
    clear_q();
    beat(hdr(7'h4A, 10'd4, 32'h01000010), 1'b0);
    beat({32'hA0B0C0D0, 32'h00000500}, 1'b0);
    beat({32'h0A0B0C0D, 32'h01020304}, 1'b0);
    beat({32'h0, 32'hCAFEBABE}, 1'b1);
    idle(2);
    n_vec++;
    if (cd.size() !== 2) begin
      n_err++;
      $display("FAIL cpl_count got %0d want 2", cd.size());
    end else begin
      n_vec++;
      if ({ct[0], cl[0], cd[0]}
          !== {8'h05, 1'b0, 64'h04030201_D0C0B0A0}) begin
        n_err++;
        $display("FAIL cpl_w0 got %h %b %h want 05 0 %h",
                 ct[0], cl[0], cd[0], 64'h04030201_D0C0B0A0);
      end
      n_vec++;
      if ({ct[1], cl[1], cd[1]}
          !== {8'h05, 1'b1, 64'hBEBAFECA_0D0C0B0A}) begin
        n_err++;
        $display("FAIL cpl_w1 got %h %b %h want 05 1 %h",
                 ct[1], cl[1], cd[1], 64'hBEBAFECA_0D0C0B0A);
      end
    end
    clear_q();
    beat(hdr(7'h4A, 10'd4, 32'h01002010), 1'b0);
    beat({32'hA0B0C0D0, 32'h00000600}, 1'b0);
    beat({32'h0A0B0C0D, 32'h01020304}, 1'b0);
    beat({32'h0, 32'hCAFEBABE}, 1'b1);
    idle(2);
    n_vec++;
    if ({cd.size(), bus.unsupported_count} !== {32'd0, 16'd2}) begin
      n_err++;
      $display("FAIL cpl_bad got %0d strobes cnt %0d want 0 2",
               cd.size(), bus.unsupported_count);
    end
  endtask

  task automatic test_unsupported();
    clear_q();
    beat(hdr(7'h60, 10'd2, 32'h0), 1'b0);
    beat({32'h00000080, 32'h00000000}, 1'b0);
    beat({32'h22222222, 32'h11111111}, 1'b1);
    idle(1);
    beat(hdr(7'h40, 10'd3, 32'h0), 1'b0);
    beat({32'h11111111, 32'h00000040}, 1'b0);
    beat({32'h33333333, 32'h22222222}, 1'b1);
    idle(2);
    n_vec++;
    if ({wa.size(), cd.size()} !== 64'd0) begin
      n_err++;
      $display("FAIL unsup_strobe got %0d %0d want 0 0",
               wa.size(), cd.size());
    end
    n_vec++;
    if (bus.unsupported_count !== 16'd4) begin
      n_err++;
      $display("FAIL unsup_cnt got %0d want 4",
               bus.unsupported_count);
    end
  endtask

  task automatic test_reset_mid();
    clear_q();
    beat(hdr(7'h40, 10'd4, 32'h0), 1'b0);
    beat({32'h55555555, 32'h00000008}, 1'b0);
    beat({32'h77777777, 32'h66666666}, 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);
    n_vec++;
    if ({wa.size(), bus.unsupported_count}
        !== {32'd0, 16'd0}) begin
      n_err++;
      $display("FAIL rst_mid got %0d strobes cnt %0d want 0 0",
               wa.size(), bus.unsupported_count);
    end
    beat(hdr(7'h40, 10'd2, 32'h0), 1'b0);
    beat({32'hAABBCCDD, 32'h00000030}, 1'b0);
    beat({32'h0, 32'h11223344}, 1'b1);
    idle(2);
    n_vec++;
    if (wa.size() !== 1) begin
      n_err++;
      $display("FAIL rst_next_count got %0d want 1", wa.size());
    end else begin
      n_vec++;
      if ({wa[0], wd[0]}
          !== {13'd6, 64'h44332211_DDCCBBAA}) begin
        n_err++;
        $display("FAIL rst_next got %h %h want 6 %h",
                 wa[0], wd[0], 64'h44332211_DDCCBBAA);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_read();
    test_read_drop();
    test_read_swap();
    test_gap();
    test_cpl();
    test_unsupported();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end
endmodule
